// File: rtl/lsu_riscv_if.sv
// Memory-side bus of the load/store unit: one request at a time,
// completed by a single-cycle ready from the memory.
interface lsu_riscv_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;

    modport master (output req, we, be, addr, wd, input rd, ready);
    modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/lsu_riscv.sv
// Load/store unit: turns one core data request into one memory bus
// transaction, stalls the core until it completes, builds byte enables and
// lane-replicated store data, extends load data and reports faults.
module lsu_riscv #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    lsu_riscv_if.master mem
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_reg;
    logic          we_reg;
    logic [2:0]    size_reg;
    logic [31:0]   addr_reg;
    logic [3:0]    be_reg;
    logic [31:0]   wd_reg;
    logic [31:0]   rd_reg;
    logic [CW-1:0] wait_reg;
    logic          mem_req_reg;
    logic          fault_reg;
    logic [1:0]    cause_reg;

    // Request decode: sizes 3, 6 and 7 are illegal; low two size bits give the width.
    logic          size_illegal;
    logic          misaligned;
    logic [3:0]    be_next;
    logic [31:0]   wd_next;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_ext;
    logic          timed_out;

    assign size_illegal = (core_size_i[1:0] == 2'd3) || (core_size_i == 3'd6);
    assign misaligned   = ((core_size_i[1:0] == 2'd1) && core_addr_i[0]) ||
                          ((core_size_i[1:0] == 2'd2) && (core_addr_i[1:0] != 2'b00));

    // Byte enables and store data replicated into every lane the width can occupy.
    always_comb begin
        be_next = 4'b1111;
        wd_next = core_wd_i;
        case (core_size_i[1:0])
            2'd0: begin
                be_next = 4'b0001 << core_addr_i[1:0];
                wd_next = {4{core_wd_i[7:0]}};
            end
            2'd1: begin
                be_next = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_next = {2{core_wd_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load alignment and sign/zero extension from the latched address and size.
    assign lane_b = mem.rd[{addr_reg[1:0], 3'b000} +: 8];
    assign lane_h = addr_reg[1] ? mem.rd[31:16] : mem.rd[15:0];

    always_comb begin
        load_ext = mem.rd;
        case (size_reg)
            3'd0:    load_ext = {{24{lane_b[7]}}, lane_b};
            3'd4:    load_ext = {24'd0, lane_b};
            3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
            3'd5:    load_ext = {16'd0, lane_h};
            default: load_ext = mem.rd;
        endcase
    end

    assign timed_out = (TIMEOUT != 0) && (wait_reg == CW'(TIMEOUT));

    // Sequencer: IDLE latches the request, ACCESS holds the bus, DONE releases the core.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            we_reg      <= 1'b0;
            size_reg    <= 3'd0;
            addr_reg    <= 32'd0;
            be_reg      <= 4'd0;
            wd_reg      <= 32'd0;
            rd_reg      <= 32'd0;
            wait_reg    <= '0;
            mem_req_reg <= 1'b0;
            fault_reg   <= 1'b0;
            cause_reg   <= 2'b00;
        end else begin
            fault_reg <= 1'b0;
            cause_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (core_req_i) begin
                        we_reg   <= core_we_i;
                        size_reg <= core_size_i;
                        addr_reg <= core_addr_i;
                        be_reg   <= be_next;
                        wd_reg   <= wd_next;
                        wait_reg <= '0;
                        if (size_illegal || misaligned) begin
                            state_reg <= DONE;
                            fault_reg <= 1'b1;
                            cause_reg <= 2'b01;
                        end else begin
                            state_reg   <= ACCESS;
                            mem_req_reg <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // Ready takes priority over a timeout reached in the same cycle.
                    if (mem.ready) begin
                        if (!we_reg) begin
                            rd_reg <= load_ext;
                        end
                        mem_req_reg <= 1'b0;
                        state_reg   <= DONE;
                    end else if (timed_out) begin
                        rd_reg      <= 32'd0;
                        mem_req_reg <= 1'b0;
                        fault_reg   <= 1'b1;
                        cause_reg   <= 2'b10;
                        state_reg   <= DONE;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are driven only while the request is up, zero otherwise.
    assign mem.req  = mem_req_reg;
    assign mem.we   = mem_req_reg & we_reg;
    assign mem.be   = be_reg & {4{mem_req_reg}};
    assign mem.addr = mem_req_reg ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign mem.wd   = mem_req_reg ? wd_reg : 32'd0;

    // Stall follows the request in IDLE so the core holds before the first edge.
    assign core_stall_o = rst_i ? 1'b0 :
                          (state_reg == IDLE) ? core_req_i : (state_reg == ACCESS);

    assign core_rd_o     = rd_reg;
    assign fault_o       = fault_reg;
    assign fault_cause_o = cause_reg;

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for lsu_riscv with a scoreboard of expected completions.
module tb_lsu_riscv;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        fault_o;
    logic [1:0]  fault_cause_o;

    lsu_riscv_if mem ();

    lsu_riscv #(.TIMEOUT(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .core_req_i    (core_req_i),
        .core_we_i     (core_we_i),
        .core_size_i   (core_size_i),
        .core_addr_i   (core_addr_i),
        .core_wd_i     (core_wd_i),
        .core_rd_o     (core_rd_o),
        .core_stall_o  (core_stall_o),
        .fault_o       (fault_o),
        .fault_cause_o (fault_cause_o),
        .mem           (mem)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        logic [1:0]  cause;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        int          stall;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One core request; memory raises ready in ACCESS cycle ready_at (0 = never).
    task automatic run_op(input string name, input logic we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int ready_at,
                          input logic [31:0] e_rd, input logic e_fault, input logic [1:0] e_cause,
                          input logic [3:0] e_be, input logic [31:0] e_wd,
                          input int e_stall, input int e_acc);
        exp_t e;
        exp_t x;
        int   stall_n = 0;
        int   acc_n   = 0;
        int   cyc     = 0;
        bit   done    = 1'b0;
        bit   bus_ok  = 1'b1;
        bit   pulse_ok = 1'b1;
        e.rd = e_rd; e.fault = e_fault; e.cause = e_cause; e.be = e_be;
        e.addr = {addr[31:2], 2'b00}; e.wd = e_wd; e.we = we;
        e.stall = e_stall; e.acc = e_acc;
        sb.push_back(e);
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = we; core_size_i = size;
        core_addr_i = addr; core_wd_i = wd; mem.rd = rdata; mem.ready = 1'b0;
        #1;
        if (core_stall_o) stall_n++;
        if (fault_o) pulse_ok = 1'b0;
        if (mem.req) bus_ok = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
            if (core_stall_o) begin
                stall_n++;
                if (fault_o) pulse_ok = 1'b0;
                if (mem.req) begin
                    acc_n++;
                    if (mem.be !== e.be || mem.addr !== e.addr ||
                        mem.wd !== e.wd || mem.we !== e.we) bus_ok = 1'b0;
                    mem.ready = (acc_n == ready_at);
                end else begin
                    mem.ready = 1'b0;
                end
            end else begin
                done = 1'b1;
                mem.ready = 1'b0;
                x = sb.pop_front();
                $display("TXN %s rd=%h fault=%0d cause=%0d stall=%0d acc=%0d",
                         name, core_rd_o, fault_o, fault_cause_o, stall_n, acc_n);
                check({name, " rd"}, core_rd_o, x.rd);
                check({name, " fault"}, 32'(fault_o), 32'(x.fault));
                check({name, " cause"}, 32'(fault_cause_o), 32'(x.cause));
                check({name, " stall"}, stall_n, x.stall);
                check({name, " access"}, acc_n, x.acc);
                check({name, " bus"}, 32'(bus_ok), 32'd1);
                check({name, " pulse"}, 32'(pulse_ok), 32'd1);
                core_req_i = 1'b0;
            end
        end
        check({name, " completed"}, 32'(done), 32'd1);
        core_req_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = 32'd0; core_wd_i = 32'd0; mem.rd = 32'd0; mem.ready = 1'b0;
        repeat (2) @(negedge clk_i);
        check("reset stall", 32'(core_stall_o), 32'd0);
        check("reset req", 32'(mem.req), 32'd0);
        check("reset rd", core_rd_o, 32'd0);
        check("reset fault", 32'(fault_o), 32'd0);
        check("reset cause", 32'(fault_cause_o), 32'd0);
        core_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op("SW",  1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1,
               32'h0, 1'b0, 2'b00, 4'b1111, 32'hDEADBEEF, 2, 1);
        run_op("SB",  1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 1,
               32'h0, 1'b0, 2'b00, 4'b1000, 32'hA5A5A5A5, 2, 1);
        run_op("SH",  1'b1, 3'd1, 32'h102, 32'h00001234, 32'h0, 1,
               32'h0, 1'b0, 2'b00, 4'b1100, 32'h12341234, 2, 1);
        run_op("LB",  1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF7F01, 4,
               32'hFFFFFF80, 1'b0, 2'b00, 4'b1000, 32'h0, 5, 4);
        run_op("LBU", 1'b0, 3'd4, 32'h202, 32'h0, 32'h80FF7F01, 4,
               32'h000000FF, 1'b0, 2'b00, 4'b0100, 32'h0, 5, 4);
        run_op("LH",  1'b0, 3'd1, 32'h202, 32'h0, 32'h80FF7F01, 4,
               32'hFFFF80FF, 1'b0, 2'b00, 4'b1100, 32'h0, 5, 4);
        run_op("LHU", 1'b0, 3'd5, 32'h200, 32'h0, 32'h80FF7F01, 4,
               32'h00007F01, 1'b0, 2'b00, 4'b0011, 32'h0, 5, 4);
        run_op("LW_MIS", 1'b0, 3'd2, 32'h101, 32'h0, 32'h12345678, 1,
               32'h00007F01, 1'b1, 2'b01, 4'b1111, 32'h0, 1, 0);
        run_op("SIZE3", 1'b0, 3'd3, 32'h100, 32'h0, 32'h12345678, 1,
               32'h00007F01, 1'b1, 2'b01, 4'b1111, 32'h0, 1, 0);
        run_op("LW_TMO", 1'b0, 3'd2, 32'h300, 32'h0, 32'h11112222, 0,
               32'h0, 1'b1, 2'b10, 4'b1111, 32'h0, 6, 5);
        run_op("LW_LATE", 1'b0, 3'd2, 32'h304, 32'h0, 32'hCAFEF00D, 5,
               32'hCAFEF00D, 1'b0, 2'b00, 4'b1111, 32'h0, 6, 5);

        // Reset asserted between clock edges while a load waits for ready.
        @(negedge clk_i);
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h400; mem.ready = 1'b0;
        repeat (3) @(negedge clk_i);
        check("mid access req", 32'(mem.req), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        $display("TXN RST_MID req=%0d stall=%0d rd=%h", mem.req, core_stall_o, core_rd_o);
        check("async rst req", 32'(mem.req), 32'd0);
        check("async rst stall", 32'(core_stall_o), 32'd0);
        check("async rst rd", core_rd_o, 32'd0);
        core_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op("LW_POST", 1'b0, 3'd2, 32'h500, 32'h0, 32'h01234567, 2,
               32'h01234567, 1'b0, 2'b00, 4'b1111, 32'h0, 3, 2);

        check("scoreboard empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
